// File: rtl/eth_seq_pkg.sv
// Shared constants for the eth_rgmii TX sequencer: register offsets, AXI codes, FSM states.
// No logic; pure declarations.
// Imported by eth_tx_sequencer and eth_axi_wr_single.
package eth_seq_pkg;

  // eth_rgmii register map (byte offsets from the slave base address)
  localparam logic [31:0] MACLO_OFF = 32'h0000_0800;
  localparam logic [31:0] MACHI_OFF = 32'h0000_0808;
  localparam logic [31:0] TXLEN_OFF = 32'h0000_0810;
  localparam logic [31:0] TXBUF_OFF = 32'h0000_1000;

  // AXI B response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AXI burst type used for every single-beat write
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_LO,
    ST_CFG_HI,
    ST_CHECK,
    ST_DATA,
    ST_LEN,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/eth_axi_wr_single.sv
// Single-beat AXI write primitive: one write in flight, AW and W launched together.
// Latency: start -> valids next cycle; done_o pulses the cycle after the B handshake.
// Backpressure: AW/W valids each held until their own ready; b_ready_o held until b_valid_i.
module eth_axi_wr_single
  import eth_seq_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   data_i,
  input  logic [DW/8-1:0] strb_i,
  output logic            done_o,
  output logic [1:0]      resp_o,
  output logic            aw_valid_o,
  input  logic            aw_ready_i,
  output logic [AW-1:0]   aw_addr_o,
  output logic            w_valid_o,
  input  logic            w_ready_i,
  output logic [DW-1:0]   w_data_o,
  output logic [DW/8-1:0] w_strb_o,
  input  logic            b_valid_i,
  output logic            b_ready_o,
  input  logic [1:0]      b_resp_i
);

  logic            r_aw_vld;
  logic            r_w_vld;
  logic            r_b_rdy;
  logic            r_done;
  logic [1:0]      r_resp;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic [DW/8-1:0] r_strb;

  // channel still waiting after this cycle's handshakes
  logic w_aw_left;
  logic w_w_left;
  logic w_busy;

  assign w_aw_left = r_aw_vld && !aw_ready_i;
  assign w_w_left  = r_w_vld && !w_ready_i;
  assign w_busy    = r_aw_vld || r_w_vld || r_b_rdy;

  // launch, retire AW/W independently, then collect exactly one B response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_vld <= 1'b0;
      r_w_vld  <= 1'b0;
      r_b_rdy  <= 1'b0;
      r_done   <= 1'b0;
      r_resp   <= RESP_OKAY;
      r_addr   <= '0;
      r_data   <= '0;
      r_strb   <= '0;
    end else begin
      r_done <= 1'b0;
      if (start_i && !w_busy) begin
        r_aw_vld <= 1'b1;
        r_w_vld  <= 1'b1;
        r_addr   <= addr_i;
        r_data   <= data_i;
        r_strb   <= strb_i;
      end else begin
        if (r_aw_vld && aw_ready_i) r_aw_vld <= 1'b0;
        if (r_w_vld && w_ready_i)   r_w_vld  <= 1'b0;
        // B is only accepted once both address and data have been taken
        if ((r_aw_vld || r_w_vld) && !w_aw_left && !w_w_left) r_b_rdy <= 1'b1;
        if (r_b_rdy && b_valid_i) begin
          r_b_rdy <= 1'b0;
          r_done  <= 1'b1;
          r_resp  <= b_resp_i;
        end
      end
    end
  end

  assign aw_valid_o = r_aw_vld;
  assign aw_addr_o  = r_addr;
  assign w_valid_o  = r_w_vld;
  assign w_data_o   = r_data;
  assign w_strb_o   = r_strb;
  assign b_ready_o  = r_b_rdy;
  assign done_o     = r_done;
  assign resp_o     = r_resp;

endmodule

// File: rtl/eth_tx_sequencer.sv
// AXI write master: programs eth_rgmii MAC regs, copies a frame to the TX buffer, writes TXLEN.
// Latency: a few cycles per write; one write outstanding at a time.
// Backpressure: cmd/data ready are registered one-cycle offers; AXI stalls simply stretch each write.
module eth_tx_sequencer
  import eth_seq_pkg::*;
#(
  parameter int          AW        = 32,
  parameter int          DW        = 64,
  parameter int          IW        = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_LEN   = 2048
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [15:0]     cmd_len_i,
  input  logic            data_valid_i,
  output logic            data_ready_o,
  input  logic [DW-1:0]   data_i,
  input  logic            cfg_update_i,
  input  logic [47:0]     mac_addr_i,
  input  logic [15:0]     cfg_flags_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  input  logic            err_clr_i,
  output logic            aw_valid_o,
  input  logic            aw_ready_i,
  output logic [AW-1:0]   aw_addr_o,
  output logic [IW-1:0]   aw_id_o,
  output logic [7:0]      aw_len_o,
  output logic [2:0]      aw_size_o,
  output logic [1:0]      aw_burst_o,
  output logic            w_valid_o,
  input  logic            w_ready_i,
  output logic [DW-1:0]   w_data_o,
  output logic [DW/8-1:0] w_strb_o,
  output logic            w_last_o,
  input  logic            b_valid_i,
  output logic            b_ready_o,
  input  logic [1:0]      b_resp_i
);

  localparam int          WIDX_W = $clog2(MAX_LEN / 8) + 1;
  localparam logic [16:0] L_MAX  = 17'(MAX_LEN);
  localparam logic [AW-1:0] A_BASE = AW'(BASE_ADDR);

  seq_state_t        r_state;
  logic              r_cfg_pend;
  logic              r_launched;
  logic              r_start;
  logic [AW-1:0]     r_wr_addr;
  logic [DW-1:0]     r_wr_data;
  logic [DW/8-1:0]   r_wr_strb;
  logic [15:0]       r_len;
  logic [WIDX_W-1:0] r_nwords;
  logic [WIDX_W-1:0] r_widx;
  logic [15:0]       r_mac_hi;
  logic [15:0]       r_flags;
  logic              r_cmd_rdy;
  logic              r_data_rdy;
  logic              r_done;
  logic              r_err;

  logic              w_wr_done;
  logic [1:0]        w_wr_resp;
  logic [16:0]       w_len_p7;

  // 17-bit sum so len = 0xFFFF cannot wrap before the shift
  assign w_len_p7 = {1'b0, r_len} + 17'd7;

  // sequencer: config writes take priority, then frame copy, then TXLEN kick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_cfg_pend <= 1'b1;
      r_launched <= 1'b0;
      r_start    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_strb  <= '0;
      r_len      <= '0;
      r_nwords   <= '0;
      r_widx     <= '0;
      r_mac_hi   <= '0;
      r_flags    <= '0;
      r_cmd_rdy  <= 1'b0;
      r_data_rdy <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_cmd_rdy <= 1'b0;
      if (err_clr_i) r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_cfg_pend) begin
            r_state <= ST_CFG_LO;
          end else if (cmd_valid_i) begin
            r_cmd_rdy <= 1'b1;
            r_len     <= cmd_len_i;
            r_state   <= ST_CHECK;
          end
        end
        ST_CFG_LO: begin
          if (!r_launched) begin
            r_launched <= 1'b1;
            r_start    <= 1'b1;
            r_wr_addr  <= A_BASE + AW'(MACLO_OFF);
            r_wr_data  <= DW'(mac_addr_i[31:0]);
            r_wr_strb  <= (DW/8)'(4'hF);
            r_mac_hi   <= mac_addr_i[47:32];
            r_flags    <= cfg_flags_i;
          end else if (w_wr_done) begin
            r_launched <= 1'b0;
            r_state    <= ST_CFG_HI;
          end
        end
        ST_CFG_HI: begin
          if (!r_launched) begin
            r_launched <= 1'b1;
            r_start    <= 1'b1;
            r_wr_addr  <= A_BASE + AW'(MACHI_OFF);
            r_wr_data  <= DW'({r_flags, r_mac_hi});
            r_wr_strb  <= (DW/8)'(4'hF);
          end else if (w_wr_done) begin
            r_launched <= 1'b0;
            r_cfg_pend <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (r_len == 16'd0 || {1'b0, r_len} > L_MAX) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_nwords   <= w_len_p7[WIDX_W+2:3];
            r_widx     <= '0;
            r_data_rdy <= 1'b0;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_widx == r_nwords) begin
            r_state <= ST_LEN;
          end else if (!r_launched) begin
            if (r_data_rdy && data_valid_i) begin
              r_data_rdy <= 1'b0;
              r_launched <= 1'b1;
              r_start    <= 1'b1;
              r_wr_addr  <= A_BASE + AW'(TXBUF_OFF) + AW'({r_widx, 3'b000});
              r_wr_data  <= data_i;
              r_wr_strb  <= '1;
            end else begin
              r_data_rdy <= 1'b1;
            end
          end else if (w_wr_done) begin
            r_launched <= 1'b0;
            r_widx     <= r_widx + 1'b1;
          end
        end
        ST_LEN: begin
          if (!r_launched) begin
            r_launched <= 1'b1;
            r_start    <= 1'b1;
            r_wr_addr  <= A_BASE + AW'(TXLEN_OFF);
            r_wr_data  <= DW'(r_len);
            r_wr_strb  <= (DW/8)'(4'hF);
          end else if (w_wr_done) begin
            r_launched <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      // a bad response is logged but the sequence carries on
      if (w_wr_done && w_wr_resp != RESP_OKAY) r_err <= 1'b1;
      // a new request always re-arms, even when CFG_HI retires in the same cycle
      if (cfg_update_i) r_cfg_pend <= 1'b1;
    end
  end

  eth_axi_wr_single #(.AW(AW), .DW(DW)) u_wr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (r_start),
    .addr_i     (r_wr_addr),
    .data_i     (r_wr_data),
    .strb_i     (r_wr_strb),
    .done_o     (w_wr_done),
    .resp_o     (w_wr_resp),
    .aw_valid_o (aw_valid_o),
    .aw_ready_i (aw_ready_i),
    .aw_addr_o  (aw_addr_o),
    .w_valid_o  (w_valid_o),
    .w_ready_i  (w_ready_i),
    .w_data_o   (w_data_o),
    .w_strb_o   (w_strb_o),
    .b_valid_i  (b_valid_i),
    .b_ready_o  (b_ready_o),
    .b_resp_i   (b_resp_i)
  );

  assign cmd_ready_o  = r_cmd_rdy;
  assign data_ready_o = r_data_rdy;
  assign busy_o       = (r_state != ST_IDLE);
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign aw_id_o      = '0;
  assign aw_len_o     = 8'd0;
  assign aw_size_o    = 3'd3;
  assign aw_burst_o   = BURST_INCR;
  assign w_last_o     = 1'b1;

endmodule

// File: tb/tb_eth_tx_sequencer.sv
// Directed bench for eth_tx_sequencer with a behavioural AXI write slave.
module tb_eth_tx_sequencer;

  localparam int LIM = 20000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [15:0] cmd_len_i = '0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic [63:0] data_i = '0;
  logic        cfg_update_i = 1'b0;
  logic [47:0] mac_addr_i = 48'h2301_0089_0702;
  logic [15:0] cfg_flags_i = 16'h8010;
  logic        busy_o, done_o, err_o;
  logic        err_clr_i = 1'b0;
  logic        aw_valid_o;
  logic        aw_ready_i = 1'b0;
  logic [31:0] aw_addr_o;
  logic [7:0]  aw_id_o;
  logic [7:0]  aw_len_o;
  logic [2:0]  aw_size_o;
  logic [1:0]  aw_burst_o;
  logic        w_valid_o;
  logic        w_ready_i = 1'b0;
  logic [63:0] w_data_o;
  logic [7:0]  w_strb_o;
  logic        w_last_o;
  logic        b_valid_i = 1'b0;
  logic        b_ready_o;
  logic [1:0]  b_resp_i = 2'b00;

  always #5 clk_i = ~clk_i;

  eth_tx_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .cfg_update_i(cfg_update_i), .mac_addr_i(mac_addr_i), .cfg_flags_i(cfg_flags_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_clr_i(err_clr_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
    .aw_id_o(aw_id_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
    .w_strb_o(w_strb_o), .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i)
  );

  int nchk = 0;
  int nerr = 0;

  // ---------------- AXI slave model (decides at negedge for the next posedge)
  logic [31:0] aw_q[$];
  logic [63:0] wd_q[$];
  logic [7:0]  ws_q[$];
  int b_cnt = 0;
  int viol = 0;
  int slverr_idx = -1;
  bit stall_en = 1'b0;
  bit b_hold = 1'b0;
  int done_cnt = 0;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      aw_ready_i = 1'b0;
      w_ready_i  = 1'b0;
      b_valid_i  = 1'b0;
      b_resp_i   = 2'b00;
      b_hold     = 1'b0;
      while (aw_q.size() > b_cnt) void'(aw_q.pop_back());
      while (wd_q.size() > b_cnt) begin
        void'(wd_q.pop_back());
        void'(ws_q.pop_back());
      end
    end else begin
      if (done_o) done_cnt++;
      // B only for a write whose AW and W were both taken at an earlier edge
      if (!b_hold && aw_q.size() > b_cnt && wd_q.size() > b_cnt &&
          (!stall_en || $urandom_range(0, 2) == 0))
        b_hold = 1'b1;
      b_valid_i = b_hold;
      b_resp_i  = (b_cnt == slverr_idx) ? 2'b10 : 2'b00;
      if (b_hold && b_ready_o) begin
        b_cnt++;
        b_hold = 1'b0;
      end
      aw_ready_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (aw_valid_o && aw_ready_i) begin
        if (aw_q.size() != b_cnt) viol++;
        aw_q.push_back(aw_addr_o);
      end
      w_ready_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_valid_o && w_ready_i) begin
        if (wd_q.size() != b_cnt) viol++;
        wd_q.push_back(w_data_o);
        ws_q.push_back(w_strb_o);
      end
    end
  end

  // ---------------- helpers (all tasks are entered at a negedge)
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] fword(input int f, input int k);
    return {8'(f), 8'hA5, 16'(k), 32'hC0DE_0000 ^ 32'(k * 3)};
  endfunction

  task automatic send_cmd(input logic [15:0] len, output bit ok);
    cmd_valid_i = 1'b1;
    cmd_len_i = len;
    ok = 1'b0;
    for (int t = 0; t < LIM; t++) begin
      if (cmd_ready_o) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d, output bit ok);
    data_valid_i = 1'b1;
    data_i = d;
    ok = 1'b0;
    for (int t = 0; t < LIM; t++) begin
      if (data_ready_o) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    data_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < LIM; t++) begin
      if (done_cnt >= target) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
  endtask

  task automatic wait_writes(input int target, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < LIM; t++) begin
      if (b_cnt >= target && !busy_o) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
  endtask

  // ---------------- vector table
  typedef struct {
    logic [15:0] len;
    int          nwr;       // expected AXI writes (buffer words + TXLEN)
    logic        err;
    bit          stall;
  } vec_t;

  vec_t tv[8];

  initial begin
    bit ok;
    int base, dbase, mism;
    logic [31:0] exp_a[$];

    tv[0] = '{16'd64,   9,   1'b0, 1'b0};
    tv[1] = '{16'd61,   9,   1'b0, 1'b1};
    tv[2] = '{16'd1,    2,   1'b0, 1'b1};
    tv[3] = '{16'd8,    2,   1'b0, 1'b0};
    tv[4] = '{16'd9,    3,   1'b0, 1'b1};
    tv[5] = '{16'd0,    0,   1'b1, 1'b0};
    tv[6] = '{16'd2049, 0,   1'b1, 1'b1};
    tv[7] = '{16'd2048, 257, 1'b0, 1'b0};

    // ---- reset state
    repeat (3) @(negedge clk_i);
    chk("reset_outputs",
        {cmd_ready_o, data_ready_o, busy_o, done_o, err_o, aw_valid_o, w_valid_o, b_ready_o},
        8'h00);
    rst_ni = 1'b1;

    // ---- initial MAC programming
    wait_writes(2, ok);
    chk("cfg_init_timeout", ok, 1);
    chk("cfg_init_count", aw_q.size(), 2);
    if (aw_q.size() >= 2) begin
      chk("cfg_lo_addr", aw_q[0], 32'h800);
      chk("cfg_lo_data", wd_q[0], 64'h0000_0000_0089_0702);
      chk("cfg_lo_strb", ws_q[0], 8'h0F);
      chk("cfg_hi_addr", aw_q[1], 32'h808);
      chk("cfg_hi_data", wd_q[1], 64'h0000_0000_8010_2301);
    end
    chk("axi_constants", {aw_id_o, aw_len_o, aw_size_o, aw_burst_o, w_last_o},
        {8'h00, 8'h00, 3'd3, 2'b01, 1'b1});

    // ---- data offered while idle is not taken
    mism = 0;
    data_valid_i = 1'b1;
    data_i = 64'h1234;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk_i);
      if (data_ready_o) mism++;
    end
    data_valid_i = 1'b0;
    chk("idle_data_not_taken", mism, 0);

    // ---- table-driven frames
    for (int v = 0; v < 8; v++) begin
      stall_en = tv[v].stall;
      pulse_clr();
      base  = b_cnt;
      dbase = done_cnt;
      send_cmd(tv[v].len, ok);
      chk($sformatf("v%0d_cmd_hs", v), ok, 1);
      if (!tv[v].err) begin
        for (int k = 0; k < tv[v].nwr - 1; k++) begin
          send_word(fword(v, k), ok);
          if (!ok) break;
        end
        chk($sformatf("v%0d_data_hs", v), ok, 1);
      end
      wait_done(dbase + 1, ok);
      chk($sformatf("v%0d_done_timeout", v), ok, 1);
      wait_writes(base + tv[v].nwr, ok);
      repeat (3) @(negedge clk_i);
      chk($sformatf("v%0d_done_pulses", v), done_cnt - dbase, 1);
      chk($sformatf("v%0d_nwrites", v), aw_q.size() - base, tv[v].nwr);
      chk($sformatf("v%0d_err", v), err_o, tv[v].err);
      if (!tv[v].err && aw_q.size() == base + tv[v].nwr) begin
        mism = 0;
        for (int k = 0; k < tv[v].nwr - 1; k++) begin
          if (aw_q[base+k] !== 32'h1000 + 32'(8 * k)) mism++;
          if (wd_q[base+k] !== fword(v, k)) mism++;
          if (ws_q[base+k] !== 8'hFF) mism++;
        end
        chk($sformatf("v%0d_buf_words", v), mism, 0);
        chk($sformatf("v%0d_txlen_addr", v), aw_q[base+tv[v].nwr-1], 32'h810);
        chk($sformatf("v%0d_txlen_data", v), wd_q[base+tv[v].nwr-1], 64'(tv[v].len));
        chk($sformatf("v%0d_txlen_strb", v), ws_q[base+tv[v].nwr-1], 8'h0F);
      end
      if (tv[v].err) begin
        pulse_clr();
        chk($sformatf("v%0d_err_clr", v), err_o, 1'b0);
      end
    end

    // ---- cfg update mid-frame plus SLVERR on buffer word 3
    stall_en = 1'b1;
    pulse_clr();
    base  = b_cnt;
    dbase = done_cnt;
    slverr_idx = base + 3;
    send_cmd(16'd40, ok);
    for (int k = 0; k < 2; k++) send_word(fword(9, k), ok);
    mac_addr_i  = 48'h0A0B_0C0D_0E0F;
    cfg_flags_i = 16'h0042;
    cfg_update_i = 1'b1;
    @(negedge clk_i);
    cfg_update_i = 1'b0;
    for (int k = 2; k < 5; k++) send_word(fword(9, k), ok);
    chk("mid_data_hs", ok, 1);
    wait_done(dbase + 1, ok);
    chk("mid_done_timeout", ok, 1);
    wait_writes(base + 8, ok);
    chk("mid_writes_timeout", ok, 1);
    exp_a = '{32'h1000, 32'h1008, 32'h1010, 32'h1018, 32'h1020, 32'h810, 32'h800, 32'h808};
    mism = 0;
    if (aw_q.size() != base + 8) mism = 99;
    else for (int k = 0; k < 8; k++) if (aw_q[base+k] !== exp_a[k]) mism++;
    chk("mid_addr_order", mism, 0);
    if (mism == 0) begin
      chk("mid_txlen_data", wd_q[base+5], 64'd40);
      chk("mid_cfg_lo_data", wd_q[base+6], 64'h0000_0000_0C0D_0E0F);
      chk("mid_cfg_hi_data", wd_q[base+7], 64'h0000_0000_0042_0A0B);
    end
    chk("slverr_sets_err", err_o, 1'b1);
    slverr_idx = -1;

    // ---- reset asserted mid-DATA (err_o is still set from the SLVERR above)
    stall_en = 1'b0;
    send_cmd(16'd32, ok);
    for (int k = 0; k < 2; k++) send_word(fword(10, k), ok);
    rst_ni = 1'b0;
    #1;
    chk("async_reset_outputs",
        {cmd_ready_o, data_ready_o, busy_o, done_o, err_o, aw_valid_o, w_valid_o, b_ready_o},
        8'h00);
    repeat (3) @(negedge clk_i);
    base = b_cnt;
    rst_ni = 1'b1;
    wait_writes(base + 2, ok);
    chk("rst_cfg_timeout", ok, 1);
    if (aw_q.size() >= base + 2) begin
      chk("rst_cfg_lo_addr", aw_q[base], 32'h800);
      chk("rst_cfg_hi_addr", aw_q[base+1], 32'h808);
    end

    chk("one_outstanding", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
